// File: rtl/button_conditioner.sv
// Conditions three raw push-buttons: 2-flop synchronizer, per-channel debounce
// filter and a one-cycle rising-edge pulse on every accepted press.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       async_nreset,
  input  logic       btn_next,
  input  logic       btn_mode,
  input  logic       btn_cyclic,
  output logic       next_led_re,
  output logic       change_mode_re,
  output logic       btn_cylic_re,
  output logic [2:0] btn_level
);

  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [2:0]       raw;
  logic [2:0]       s1_q;
  logic [2:0]       s2_q;
  logic [2:0]       acc_q;
  logic [2:0]       acc_d;
  logic [2:0]       pulse_q;
  logic [2:0]       pulse_d;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];

  // Channel order matches btn_level: bit 0 next, bit 1 mode, bit 2 cyclic.
  assign raw = {btn_cyclic, btn_mode, btn_next};

  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
    end
  end

  // Any sample that agrees with the accepted level restarts the count.
  always_comb begin
    acc_d = acc_q;
    for (int ch = 0; ch < 3; ch++) begin
      cnt_d[ch] = '0;
      if (s2_q[ch] != acc_q[ch]) begin
        if (cnt_q[ch] == CNT_LAST) begin
          acc_d[ch] = s2_q[ch];
        end else begin
          cnt_d[ch] = cnt_q[ch] + 1'b1;
        end
      end
    end
    pulse_d = acc_d & ~acc_q;
  end

  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      acc_q   <= '0;
      pulse_q <= '0;
      for (int ch = 0; ch < 3; ch++) begin
        cnt_q[ch] <= '0;
      end
    end else begin
      acc_q   <= acc_d;
      pulse_q <= pulse_d;
      for (int ch = 0; ch < 3; ch++) begin
        cnt_q[ch] <= cnt_d[ch];
      end
    end
  end

  assign next_led_re    = pulse_q[0];
  assign change_mode_re = pulse_q[1];
  assign btn_cylic_re   = pulse_q[2];
  assign btn_level      = acc_q;

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 4, consecutive synchronized cycles a raw level must differ from the accepted level before it is accepted; legal range 1..1048576.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: async_nreset  input  1  reset, asynchronous, active-low.
REQ-004 Port: btn_next  input  1  raw push-button, active-high, asynchronous to clk, may bounce.
REQ-005 Port: btn_mode  input  1  raw push-button, active-high, asynchronous to clk, may bounce.
REQ-006 Port: btn_cyclic  input  1  raw push-button, active-high, asynchronous to clk, may bounce.
REQ-007 Port: next_led_re  output  1  one-cycle pulse on accepted press of btn_next; feeds the LED driver next_led_re input.
REQ-008 Port: change_mode_re  output  1  one-cycle pulse on accepted press of btn_mode; feeds change_mode_re.
REQ-009 Port: btn_cylic_re  output  1  one-cycle pulse on accepted press of btn_cyclic; feeds btn_cylic_re.
REQ-010 Port: btn_level  output  3  accepted (debounced) levels, {cyclic, mode, next}.

Function
REQ-011 Three identical, fully independent channels: next, mode, cyclic; no interaction between channels.
REQ-012 Per channel: 2-flop synchronizer (s1 <= raw, s2 <= s1); only s2 used downstream.
REQ-013 Per channel: accepted level register acc and debounce counter cnt, width ceil(log2(DEBOUNCE_CYCLES))+1 bits, never wraps.
REQ-014 Per edge: s2 == acc -> cnt <= 0, acc unchanged.
REQ-015 Per edge: s2 != acc and cnt < DEBOUNCE_CYCLES-1 -> cnt <= cnt+1.
REQ-016 Per edge: s2 != acc and cnt == DEBOUNCE_CYCLES-1 -> acc <= s2, cnt <= 0.
REQ-017 Any single-cycle return of s2 to acc restarts the count from 0 (glitch rejection).
REQ-018 Pulse output registered: pulse <= 1 on the edge where acc transitions 0->1, else 0; high exactly one cycle per accepted press.
REQ-019 Accepted release (acc 1->0) produces no pulse; holding a button produces exactly one pulse.
REQ-020 Latency: raw held high from before edge E0 -> s2 high after E0+1, pulse high during the cycle after edge E0+DEBOUNCE_CYCLES+1, low after the next edge.
REQ-021 Re-press: next pulse requires an accepted release (DEBOUNCE_CYCLES stable-low s2 cycles) followed by an accepted press.
REQ-022 DEBOUNCE_CYCLES == 1: one s2 mismatch cycle suffices; no glitch filtering beyond synchronizer.
REQ-023 Simultaneous presses on several channels: each channel pulses on its own schedule; same-cycle pulses allowed.
REQ-024 btn_level equals {acc_cyclic, acc_mode, acc_next}, updated in the same cycle as acc.

Reset
REQ-025 async_nreset low: immediately clear s1, s2, acc, cnt, pulse for all channels; all outputs 0.
REQ-026 Reset asserted mid-count or during a pulse aborts it; no pulse is emitted for that press on release.
REQ-027 After reset release with a button already held high: treated as a new press; pulse per REQ-020 counted from the first edge after release.

Verification (DEBOUNCE_CYCLES = 4 unless stated)
REQ-028 Reset 0 for 5 time units then 1, buttons low -> all pulses and btn_level stay 0 for 200 cycles.
REQ-029 btn_next raised before edge E0, held 20 cycles -> next_led_re high only during the cycle after E0+5; btn_level[0]=1 from then on; other outputs 0.
REQ-030 btn_mode toggled 1/0 every cycle for 30 cycles, then low -> change_mode_re never asserts; btn_level[1] stays 0.
REQ-031 btn_cyclic high 3 cycles, low 1, high 10 -> exactly one btn_cylic_re pulse, 5 edges after the final rising sample.
REQ-032 btn_next held 20 cycles, released 2 cycles, held again 20 -> exactly one pulse (release not accepted); released 10 cycles, pressed again -> second pulse.
REQ-033 All three raised on the same cycle -> all three pulses assert in the same cycle; async_nreset pulsed low 2 cycles into the count -> no pulse until counting restarts after release.
